rat_regfile: RTL
================

Name: rat_regfile

Overview:
- Architectural register file merged with a register alias table (RAT) for the Tomasulo core.
- Sits directly downstream of the reorder buffer (ROB) and beside dispatch.
  - Renames rd to a ROB tag when an instruction is dispatched.
  - Supplies rs1/rs2 value or producing tag to the reservation stations.
  - Retires committed results into architectural state.
  - Rebuilds the alias table after a branch/JALR flush from the surviving ROB contents.

Parameters:
- width, 32, data width.
- rob_size, 8, ROB entries; also the number of commit/rebuild lanes.
- tag_width, 4, ROB tag width.
- num_regs, 32, architectural registers.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reg_ld_instr  in  1  dispatch of an rd-writing instruction this cycle
- rd  in  5  destination of the dispatching instruction
- rd_tag  in  tag_width  ROB tag allocated to the dispatching instruction
- rs1, rs2  in  5 each  source register indices
- rs1_data, rs2_data  out  width each  register value
- rs1_busy, rs2_busy  out  1 each  value pending; use rsX_tag
- rs1_tag, rs2_tag  out  tag_width each  producing ROB tag when busy
- commit_valid[rob_size]  in  1  lane i retires ROB entry with tag i this cycle
- commit_rd[rob_size]  in  5  destination for lane i
- commit_data[rob_size]  in  width  result for lane i
- rob_front_tag  in  tag_width  oldest ROB entry (age-order origin)
- rob_entry_valid[rob_size]  in  1  ROB slot holds a live instruction
- rob_entry_wr[rob_size]  in  1  ROB slot writes rd (not br/store, rd≠0)
- rob_entry_rd[rob_size]  in  5  rd of each ROB slot
- flush_valid  in  1  mispredict/JALR flush this cycle
- flush_tag  in  tag_width  first squashed tag; survivors are [rob_front_tag, flush_tag) modulo rob_size

Behaviour:
- State per register: data[width], busy, tag. Reset: all data 0, busy 0, tag 0. Outputs are combinational, so after reset all read outputs are 0.
- x0:
  - Reads always return data 0, busy 0, tag 0.
  - Rename and commit to x0 are ignored.
- Read path (combinational, same cycle):
  - Returns registered state with commit bypass. If any commit lane this cycle writes rsX and its tag equals the current rsX tag while busy, output that lane's data with busy=0.
  - Reads never observe the same-cycle rename: rs1==rd yields the older producer.
- Commit (posedge), lanes processed in age order starting at rob_front_tag, wrapping modulo rob_size:
  - data[commit_rd] <= commit_data.
  - Clear busy only if the register's tag equals the lane index; a younger rename keeps the register busy.
  - When several lanes write the same rd, the youngest lane's data wins.
- Rename (posedge, when reg_ld_instr & ~flush_valid):
  - busy[rd] <= 1 and tag[rd] <= rd_tag.
  - Overrides the commit busy-clear for the same rd in the same cycle; the commit data write still occurs.
- Flush (posedge, when flush_valid):
  - Commits for this cycle are applied first.
  - Rename is ignored.
  - Every register's busy/tag is rebuilt. A tag t is a survivor iff rob_entry_valid[t] & rob_entry_wr[t] & ~commit_valid[t] & t lies in [rob_front_tag, flush_tag) in age order.
  - For each register, the youngest surviving writer sets busy=1 and tag=t; if none, busy=0.
  - When flush_tag==rob_front_tag, no entries survive and all registers become non-busy.
  - Data is never altered by a flush.
- rst has priority over all events; reset asserted mid-operation clears all state on that edge.
- No stalls; single-cycle latency for all updates.

Decomposition:
- Shared package (rv32i_types):
  - regfile_entry_t {data, busy, tag}.
  - Constants for num_regs and tag width.
  - The existing flush_t type carries flush_valid and flush_tag to the top level.
- Sub-module rat_rebuild: purely combinational.
  - Inputs: ROB valid/wr/rd arrays, front, flush_tag, commit mask.
  - Output: per-register {busy, tag} rebuilt table.
  - Keeps the age-ordered scan out of the sequential core.

Test Plan:
- Reset, then read rs1=5 → data 0, busy 0. Rename x5→tag 3, next cycle read x5 → busy 1, tag 3. Commit lane 3 rd 5 data 0xDEAD → same-cycle read shows 0xDEAD with busy 0; next cycle busy 0.
- Rename x7→tag 1, then x7→tag 2. Commit tag 1 data 0x11 → x7 stays busy with tag 2, data 0x11. Commit tag 2 data 0x22 → x7 not busy, data 0x22.
- Same-cycle commit tag 4 (x9, 0x44) and rename x9→tag 6 → x9 busy, tag 6, data 0x44. Read rs1=rd=x9 that cycle → busy 1, tag 4 bypassed to data 0x44, busy 0.
- Front=6; ROB tags 6,7,0,1 valid writing x3,x4,x3,x3. Flush_tag=0 → x3 tag 6 busy, x4 tag 7 busy; other regs not busy. Rename presented that cycle is dropped.
- Wrap case: front=5, flush_tag=front → all registers non-busy, data unchanged.
- Writes to x0 via rename and commit → x0 reads 0 and is never busy.

Source files
------------

// File: rtl/rat_regfile_pkg.sv
// rat_regfile_pkg: shared types for rat_regfile (register entry, RAT entry, flush bundle, age-order lane helper)
package rat_regfile_pkg;
  localparam int WIDTH = 32;
  localparam int ROB_SIZE = 8;
  localparam int TAG_WIDTH = 4;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic busy;
    logic [TAG_WIDTH-1:0] tag;
  } regfile_entry_t;
  typedef struct packed {
    logic busy;
    logic [TAG_WIDTH-1:0] tag;
  } rat_entry_t;
  typedef struct packed {
    logic valid;
    logic [TAG_WIDTH-1:0] tag;
  } flush_t;
  function automatic int age_lane(input int front, input int i, input int n);
    return (front + i) % n;
  endfunction
endpackage

// File: rtl/rat_regfile_rebuild.sv
// rat_regfile_rebuild: combinational RAT rebuild; ports i_valid/i_wr/i_rd (ROB slots), i_front, i_flush_tag, i_commit (mask) -> o_rat per-register {busy, tag}
module rat_regfile_rebuild
  import rat_regfile_pkg::*;
#(
  parameter int rob_size = ROB_SIZE,
  parameter int tag_width = TAG_WIDTH,
  parameter int num_regs = NUM_REGS
) (
  input  logic [rob_size-1:0]  i_valid,
  input  logic [rob_size-1:0]  i_wr,
  input  logic [4:0]           i_rd [rob_size],
  input  logic [tag_width-1:0] i_front,
  input  logic [tag_width-1:0] i_flush_tag,
  input  logic [rob_size-1:0]  i_commit,
  output rat_entry_t           o_rat [num_regs]
);
  int w_front;
  int w_cnt;
  assign w_front = int'(i_front) % rob_size;
  assign w_cnt = (int'(i_flush_tag) % rob_size - w_front + rob_size) % rob_size;
  always_comb begin
    for (int r = 0; r < num_regs; r++) o_rat[r] = '0;
    for (int i = 0; i < rob_size; i++)
      if (i < w_cnt && i_valid[age_lane(w_front, i, rob_size)] && i_wr[age_lane(w_front, i, rob_size)] &&
          !i_commit[age_lane(w_front, i, rob_size)] && |i_rd[age_lane(w_front, i, rob_size)])
        o_rat[i_rd[age_lane(w_front, i, rob_size)]] = '{busy: 1'b1, tag: TAG_WIDTH'(age_lane(w_front, i, rob_size))};
  end
endmodule

// File: rtl/rat_regfile.sv
// rat_regfile: register file + RAT; dispatch (reg_ld_instr/rd/rd_tag) renames, rs1/rs2 read value-or-tag with commit bypass, commit_* lanes retire in age order from rob_front_tag, flush_* rebuilds busy/tag from rob_entry_*
module rat_regfile
  import rat_regfile_pkg::*;
#(
  parameter int width = WIDTH,
  parameter int rob_size = ROB_SIZE,
  parameter int tag_width = TAG_WIDTH,
  parameter int num_regs = NUM_REGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reg_ld_instr,
  input  logic [4:0]           rd,
  input  logic [tag_width-1:0] rd_tag,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic [width-1:0]     rs1_data,
  output logic [width-1:0]     rs2_data,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [tag_width-1:0] rs1_tag,
  output logic [tag_width-1:0] rs2_tag,
  input  logic [rob_size-1:0]  commit_valid,
  input  logic [4:0]           commit_rd [rob_size],
  input  logic [width-1:0]     commit_data [rob_size],
  input  logic [tag_width-1:0] rob_front_tag,
  input  logic [rob_size-1:0]  rob_entry_valid,
  input  logic [rob_size-1:0]  rob_entry_wr,
  input  logic [4:0]           rob_entry_rd [rob_size],
  input  logic                 flush_valid,
  input  logic [tag_width-1:0] flush_tag
);
  flush_t w_flush;
  regfile_entry_t r_regs [num_regs];
  regfile_entry_t w_nx [num_regs];
  regfile_entry_t w_rd [2];
  rat_entry_t w_rat [num_regs];
  logic [4:0] w_rs [2];
  int w_lane [rob_size];
  assign w_flush = '{valid: flush_valid, tag: flush_tag};
  assign w_rs[0] = rs1;
  assign w_rs[1] = rs2;
  rat_regfile_rebuild #(.rob_size(rob_size), .tag_width(tag_width), .num_regs(num_regs)) u_rebuild (
    .i_valid(rob_entry_valid),
    .i_wr(rob_entry_wr),
    .i_rd(rob_entry_rd),
    .i_front(rob_front_tag),
    .i_flush_tag(w_flush.tag),
    .i_commit(commit_valid),
    .o_rat(w_rat)
  );
  always_comb
    for (int i = 0; i < rob_size; i++) w_lane[i] = age_lane(int'(rob_front_tag) % rob_size, i, rob_size);
  always_comb begin
    w_nx = r_regs;
    for (int i = 0; i < rob_size; i++)
      if (commit_valid[w_lane[i]] && |commit_rd[w_lane[i]]) begin
        w_nx[commit_rd[w_lane[i]]].data = commit_data[w_lane[i]];
        if (r_regs[commit_rd[w_lane[i]]].tag == tag_width'(w_lane[i])) w_nx[commit_rd[w_lane[i]]].busy = 1'b0;
      end
    for (int r = 0; r < num_regs; r++)
      if (w_flush.valid) begin
        w_nx[r].busy = w_rat[r].busy;
        w_nx[r].tag = w_rat[r].tag;
      end
    if (!w_flush.valid && reg_ld_instr && |rd) begin
      w_nx[rd].busy = 1'b1;
      w_nx[rd].tag = rd_tag;
    end
  end
  always_comb
    for (int p = 0; p < 2; p++) begin
      w_rd[p] = r_regs[w_rs[p]];
      for (int i = 0; i < rob_size; i++)
        if (r_regs[w_rs[p]].busy && commit_valid[i] && commit_rd[i] == w_rs[p] &&
            r_regs[w_rs[p]].tag == tag_width'(i)) begin
          w_rd[p].data = commit_data[i];
          w_rd[p].busy = 1'b0;
        end
      w_rd[p] = |w_rs[p] ? w_rd[p] : '0;
    end
  assign rs1_data = w_rd[0].data;
  assign rs1_busy = w_rd[0].busy;
  assign rs1_tag = w_rd[0].tag;
  assign rs2_data = w_rd[1].data;
  assign rs2_busy = w_rd[1].busy;
  assign rs2_tag = w_rd[1].tag;
  always_ff @(posedge clk)
    if (rst) r_regs <= '{default: '0};
    else r_regs <= w_nx;
endmodule
